cbx_param: RTL and testbench

Parametrised X-channel connection block, the generalised successor of the fixed 11-track, 9-pin bottom-edge connection blocks. It passes CHAN_W tracks straight through in both directions and drives NUM_PINS grid input pins through MUX_SIZE-input select muxes. It adds behaviour the fixed blocks lack: a shadow configuration chain with a bit counter, atomic commit, output gating before first commit, out-of-range select detection, and an optional registered pin output. It sits between adjacent switch blocks on the channel, with its configuration chain spliced into the fabric's ccff daisy chain.

---
 rtl/cb_pkg.sv | 28 ++
 rtl/cb_cfg_chain.sv | 71 +++++++
 rtl/cbx_param.sv | 94 +++++++++
 tb/tb_cbx_param.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cb_pkg.sv
// Shared helpers for the parametrised connection block:
// track mapping, config sizing and direction encodings.
package cb_pkg;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int cfg_bits_of(input int num_pins, input int mux_size);
        return num_pins * clog2(mux_size);
    endfunction

    // Mux input pair k of pin p taps this track; pairs past the first
    // two stride by 4 with a per-pin offset to spread pin coverage.
    function automatic int cb_track(input int p, input int k, input int chan_w);
        if (k < 2) return k;
        return (2 + p + 4 * (k - 2)) % chan_w;
    endfunction

endpackage

// File: rtl/cb_cfg_chain.sv
// Shadow configuration chain with bit counter, atomic commit
// and sticky error tracking.
module cb_cfg_chain
    import cb_pkg::*;
#(
    parameter int NUM_PINS = 9,
    parameter int MUX_SIZE = 10,
    parameter int SEL_W    = clog2(MUX_SIZE),
    parameter int CFG_BITS = NUM_PINS * SEL_W
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    input  logic                ccff_head,
    input  logic                cfg_en,
    input  logic                cfg_commit,
    output logic                ccff_tail,
    output logic [CFG_BITS-1:0] active_cfg,
    output logic                cfg_done,
    output logic                cfg_valid,
    output logic                cfg_err
);

    localparam int CNT_W = clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [SEL_W:0]   SEL_LIM  = (SEL_W + 1)'(MUX_SIZE);

    logic [CFG_BITS-1:0] shreg;
    logic [CNT_W-1:0]    bit_cnt;
    logic                shadow_bad;
    logic                commit_ok;

    assign cfg_done  = (bit_cnt == CNT_FULL);
    assign ccff_tail = shreg[CFG_BITS-1];
    assign commit_ok = cfg_commit && cfg_done;

    // Out-of-range selects are caught as they are committed so that
    // the error flag moves on the same edge as the active config.
    always_comb begin
        shadow_bad = 1'b0;
        for (int p = 0; p < NUM_PINS; p++) begin
            if ({1'b0, shreg[p*SEL_W +: SEL_W]} >= SEL_LIM)
                shadow_bad = 1'b1;
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            active_cfg <= '0;
            cfg_valid  <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            if (cfg_en)
                shreg <= {shreg[CFG_BITS-2:0], ccff_head};
            if (commit_ok) begin
                active_cfg <= shreg;
                cfg_valid  <= 1'b1;
                bit_cnt    <= cfg_en ? CNT_W'(1) : '0;
                if (shadow_bad)
                    cfg_err <= 1'b1;
            end else begin
                if (cfg_commit)
                    cfg_err <= 1'b1;
                if (cfg_en && !cfg_done)
                    bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cbx_param.sv
// Parametrised X-channel connection block: straight-through tracks
// plus configurable grid-pin select muxes.
module cbx_param
    import cb_pkg::*;
#(
    parameter int CHAN_W   = 11,
    parameter int NUM_PINS = 9,
    parameter int MUX_SIZE = 10,
    parameter int REG_OUT  = 0
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    input  logic [CHAN_W-1:0]   chanx_left_in,
    input  logic [CHAN_W-1:0]   chanx_right_in,
    output logic [CHAN_W-1:0]   chanx_left_out,
    output logic [CHAN_W-1:0]   chanx_right_out,
    input  logic                ccff_head,
    input  logic                cfg_en,
    input  logic                cfg_commit,
    output logic                ccff_tail,
    output logic [NUM_PINS-1:0] pin_out,
    output logic                cfg_done,
    output logic                cfg_valid,
    output logic                cfg_err
);

    localparam int SEL_W    = clog2(MUX_SIZE);
    localparam int CFG_BITS = cfg_bits_of(NUM_PINS, MUX_SIZE);
    localparam logic [SEL_W:0] SEL_LIM = (SEL_W + 1)'(MUX_SIZE);

    logic [CFG_BITS-1:0] active_cfg;
    logic [NUM_PINS-1:0] pin_d;
    logic [NUM_PINS-1:0] sel_oor;

    assign chanx_right_out = chanx_left_in;
    assign chanx_left_out  = chanx_right_in;

    cb_cfg_chain #(
        .NUM_PINS (NUM_PINS),
        .MUX_SIZE (MUX_SIZE),
        .SEL_W    (SEL_W),
        .CFG_BITS (CFG_BITS)
    ) u_cfg (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .ccff_head    (ccff_head),
        .cfg_en       (cfg_en),
        .cfg_commit   (cfg_commit),
        .ccff_tail    (ccff_tail),
        .active_cfg   (active_cfg),
        .cfg_done     (cfg_done),
        .cfg_valid    (cfg_valid),
        .cfg_err      (cfg_err)
    );

    for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
        logic [SEL_W-1:0] sel;
        logic             hit;

        assign sel        = active_cfg[p*SEL_W +: SEL_W];
        assign sel_oor[p] = ({1'b0, sel} >= SEL_LIM);

        // Even inputs tap the left side, odd inputs the right side.
        always_comb begin
            hit = 1'b0;
            for (int j = 0; j < MUX_SIZE; j++) begin
                if (sel == SEL_W'(j)) begin
                    if ((j % 2) == int'(RIGHT))
                        hit = chanx_right_in[cb_track(p, j / 2, CHAN_W)];
                    else
                        hit = chanx_left_in[cb_track(p, j / 2, CHAN_W)];
                end
            end
        end

        assign pin_d[p] = cfg_valid & ~sel_oor[p] & hit;
    end

    if (REG_OUT != 0) begin : g_reg
        logic [NUM_PINS-1:0] pin_q;

        always_ff @(posedge prog_clk or negedge prog_reset_n) begin
            if (!prog_reset_n)
                pin_q <= '0;
            else
                pin_q <= pin_d;
        end

        assign pin_out = pin_q;
    end else begin : g_comb
        assign pin_out = pin_d;
    end

endmodule

// File: tb/tb_cbx_param.sv
// Directed bench for cbx_param: combinational and registered
// instances share stimulus and are checked against hand values.
module tb_cbx_param;

    localparam int CW = 11;
    localparam int NP = 9;
    localparam int CB = 36;

    logic          prog_clk = 1'b0;
    logic          prog_reset_n = 1'b0;
    logic [CW-1:0] left_in = '0;
    logic [CW-1:0] right_in = '0;
    logic          ccff_head = 1'b0;
    logic          cfg_en = 1'b0;
    logic          cfg_commit = 1'b0;

    logic [CW-1:0] left_out, right_out, left_out_r, right_out_r;
    logic [NP-1:0] pin_out, pin_out_r;
    logic ccff_tail, cfg_done, cfg_valid, cfg_err;
    logic ccff_tail_r, cfg_done_r, cfg_valid_r, cfg_err_r;

    int nvec = 0;
    int nerr = 0;

    always #5 prog_clk = ~prog_clk;

    cbx_param #(.CHAN_W(CW), .NUM_PINS(NP), .MUX_SIZE(10), .REG_OUT(0)) dut (
        .prog_clk        (prog_clk),
        .prog_reset_n    (prog_reset_n),
        .chanx_left_in   (left_in),
        .chanx_right_in  (right_in),
        .chanx_left_out  (left_out),
        .chanx_right_out (right_out),
        .ccff_head       (ccff_head),
        .cfg_en          (cfg_en),
        .cfg_commit      (cfg_commit),
        .ccff_tail       (ccff_tail),
        .pin_out         (pin_out),
        .cfg_done        (cfg_done),
        .cfg_valid       (cfg_valid),
        .cfg_err         (cfg_err)
    );

    cbx_param #(.CHAN_W(CW), .NUM_PINS(NP), .MUX_SIZE(10), .REG_OUT(1)) dut_r (
        .prog_clk        (prog_clk),
        .prog_reset_n    (prog_reset_n),
        .chanx_left_in   (left_in),
        .chanx_right_in  (right_in),
        .chanx_left_out  (left_out_r),
        .chanx_right_out (right_out_r),
        .ccff_head       (ccff_head),
        .cfg_en          (cfg_en),
        .cfg_commit      (cfg_commit),
        .ccff_tail       (ccff_tail_r),
        .pin_out         (pin_out_r),
        .cfg_done        (cfg_done_r),
        .cfg_valid       (cfg_valid_r),
        .cfg_err         (cfg_err_r)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic do_reset();
        prog_reset_n = 1'b0;
        cfg_en = 1'b0;
        cfg_commit = 1'b0;
        #3;
        tick();
        prog_reset_n = 1'b1;
    endtask

    // MSB of the word goes in first so it ends up in pin NP-1's select MSB.
    task automatic shift_word(input logic [CB-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            ccff_head = w[CB-1-i];
            cfg_en = 1'b1;
            tick();
        end
        cfg_en = 1'b0;
        ccff_head = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    logic [CB-1:0]   wa, wb;
    logic [2*CB-1:0] stream;
    logic [NP-1:0]   exp_pin;

    initial begin
        // Reset state
        #2;
        chk("rst_pin", pin_out, 0);
        chk("rst_pin_r", pin_out_r, 0);
        chk("rst_done", cfg_done, 0);
        chk("rst_valid", cfg_valid, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_tail", ccff_tail, 0);
        do_reset();

        // Full load: pin0 sel=7 (right track 6), others sel=0 (left track 0)
        wa = 36'h0_0000_0007;
        shift_word(wa, CB);
        chk("t1_done", cfg_done, 1);
        chk("t1_valid_pre", cfg_valid, 0);
        commit();
        chk("t1_valid", cfg_valid, 1);
        chk("t1_err", cfg_err, 0);
        chk("t1_done_after", cfg_done, 0);
        left_in = 11'h001; right_in = 11'h000;
        #1 chk("t1_pin_a", pin_out, 9'h1FE);
        left_in = 11'h7FE; right_in = 11'h040;
        #1 chk("t1_pin_b", pin_out, 9'h001);
        left_in = 11'h000; right_in = 11'h7BF;
        #1 chk("t1_pin_c", pin_out, 9'h000);
        tick();
        chk("t1_pin_r", pin_out_r, 9'h000);

        // Early commit is rejected and latches the error
        do_reset();
        left_in = '1; right_in = '1;
        shift_word(wa, 20);
        chk("t2_done_early", cfg_done, 0);
        commit();
        chk("t2_err", cfg_err, 1);
        chk("t2_valid", cfg_valid, 0);
        chk("t2_pin", pin_out, 0);
        shift_word(wa, CB);
        commit();
        chk("t2_valid_full", cfg_valid, 1);
        chk("t2_err_sticky", cfg_err, 1);
        chk("t2_pin_full", pin_out, 9'h1FF);

        // pin3 sel=12 is out of range; pin0 sel=1 (right track 0)
        do_reset();
        wa = 36'h0_0000_C001;
        shift_word(wa, CB);
        commit();
        chk("t3_valid", cfg_valid, 1);
        chk("t3_err", cfg_err, 1);
        left_in = '1; right_in = '1;
        #1 chk("t3_pin_ones", pin_out, 9'h1F7);
        left_in = '0; right_in = 11'h001;
        #1 chk("t3_pin_r0", pin_out, 9'h001);
        left_in = 11'h001; right_in = 11'h000;
        #1 chk("t3_pin_l0", pin_out, 9'h1F6);

        // 72-bit stream with a commit overlapping the 37th shift
        do_reset();
        wa = 36'h0_0000_0007;
        wb = 36'h9_8765_4321;
        stream = {wa, wb};
        for (int i = 0; i < 2 * CB; i++) begin
            ccff_head = stream[2*CB-1-i];
            cfg_en = 1'b1;
            cfg_commit = (i == CB);
            tick();
            if (i >= CB - 1)
                chk($sformatf("t4_tail%0d", i + 1 - CB), ccff_tail,
                    stream[2*CB-1-(i+1-CB)]);
            if (i == CB) begin
                chk("t4_valid", cfg_valid, 1);
                chk("t4_done_cnt1", cfg_done, 0);
            end
        end
        cfg_en = 1'b0;
        cfg_commit = 1'b0;
        chk("t4_done_end", cfg_done, 1);
        chk("t4_err", cfg_err, 0);
        left_in = 11'h000; right_in = 11'h040;
        #1 chk("t4_pin_a", pin_out, 9'h001);
        left_in = 11'h001; right_in = 11'h000;
        #1 chk("t4_pin_b", pin_out, 9'h1FE);

        // Registered outputs lag by one clock; reset clears at once
        do_reset();
        shift_word('0, CB);
        commit();
        left_in = '0; right_in = '0;
        tick();
        chk("t5_r_idle", pin_out_r, 0);
        left_in = 11'h001;
        #1 chk("t5_comb_now", pin_out, 9'h1FF);
        chk("t5_r_before", pin_out_r, 0);
        tick();
        chk("t5_r_after", pin_out_r, 9'h1FF);
        left_in = 11'h000;
        #1 chk("t5_r_hold", pin_out_r, 9'h1FF);
        tick();
        chk("t5_r_fall", pin_out_r, 0);
        left_in = 11'h001;
        tick();
        cfg_en = 1'b1; ccff_head = 1'b1;
        tick();
        #2 prog_reset_n = 1'b0;
        #1 chk("t5_rst_pin_r", pin_out_r, 0);
        chk("t5_rst_valid_r", cfg_valid_r, 0);
        chk("t5_rst_valid", cfg_valid, 0);
        chk("t5_rst_tail", ccff_tail, 0);
        cfg_en = 1'b0; ccff_head = 1'b0;

        // Pass-through random walk, in and out of reset
        for (int i = 0; i < 16; i++) begin
            if (i == 8) prog_reset_n = 1'b1;
            left_in = CW'($urandom);
            right_in = CW'($urandom);
            #1;
            chk("pt_right", right_out, left_in);
            chk("pt_left", left_out, right_in);
            chk("pt_right_r", right_out_r, left_in);
            chk("pt_left_r", left_out_r, right_in);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
